// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address split, frame
// layout and controller state encoding, plus a saturating increment helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default instruction-cache geometry (16 one-word frames).
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 26;

  // Fetch address split for the default geometry: 26/4/2.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // One cache frame: valid bit, tag and a single instruction word.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits are returned
// combinationally in IDLE; a miss captures the word address and runs a
// single-word fill from memory in FILL, after which the refetch hits.
module icache
  import cpu_types_pkg::*;
#(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  // datapath side
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  // memory controller side
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  // performance counters
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  // Controller state and captured miss address
  icache_state_t state_q, state_d;
  word_t         addr_q, addr_d;

  // Saturating performance counters
  word_t         hit_cnt_q, hit_cnt_d;
  word_t         miss_cnt_q, miss_cnt_d;

  // Frame storage: valid bits are reset, tag/data arrays are not
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  // Request decode and fill target decode
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             fill_we;

  // Byte offset of the fetch address plays no part in the lookup.
  logic unused_byte_offset;
  assign unused_byte_offset = ^imemaddr[1:0];

  assign req_tag  = imemaddr[31:32-TAG_W];
  assign req_idx  = imemaddr[IDX_W+1:2];
  assign fill_tag = addr_q[31:32-TAG_W];
  assign fill_idx = addr_q[IDX_W+1:2];

  // Lookup and output drive: hits only in IDLE, memory request only in FILL
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and infers a latch.
    hit      = 1'b0;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (state_q == IDLE) begin
      hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
      if (hit) begin
        ihit     = 1'b1;
        imemload = data_q[req_idx];
      end
    end else begin
      iREN  = 1'b1;
      iaddr = addr_q;
    end
  end

  // Next-state logic: start a fill on a miss, finish it when memory answers
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (imemREN) begin
          addr_d     = {imemaddr[31:2], 2'b00};
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = FILL;
        end
      end
      FILL: begin
        // The fill runs to completion even if the datapath drops its request.
        if (!iwait) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values, independent of block ordering.
      state_q    <= IDLE;
      addr_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data array write on fill completion
  // NOTE: the tag and data arrays carry no reset; the cleared valid bits
  // make their power-up contents unobservable, and leaving them unreset
  // keeps them mappable onto plain storage.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table-driven directed fetches, hand-written
// multi-cycle sequences (address change during fill, reset mid-fill, counter
// saturation) and a randomized run against a direct-mapped reference model.
module tb_icache;
  import cpu_types_pkg::*;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 0;

  icache #(.SETS(SETS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  // Backing memory: a few fixed words, everything else a hash of the address.
  word_t mem_over [logic [29:0]];

  function automatic word_t mem_data(input logic [29:0] w);
    if (mem_over.exists(w)) return mem_over[w];
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Memory responder: holds iwait high for mem_lat cycles of a request,
  // then returns the word with iwait low. Garbage on iload otherwise.
  initial begin
    int wcnt;
    wcnt  = 0;
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    forever begin
      @(negedge CLK);
      if (iREN) begin
        if (wcnt >= mem_lat) begin
          iwait = 1'b0;
          iload = mem_data(iaddr[31:2]);
          wcnt  = 0;
        end else begin
          iwait = 1'b1;
          iload = 32'hBAD0_0000 ^ word_t'(wcnt);
          wcnt++;
        end
      end else begin
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        wcnt  = 0;
      end
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One fetch held until ihit: checks hit latency, data, memory request
  // address and the counters afterwards.
  task automatic fetch(input word_t a, input int lat, input bit exp_hit,
                       input word_t exp_data, input word_t exp_hits,
                       input word_t exp_misses, input string nm);
    int got;
    int want;
    got     = -1;
    want    = exp_hit ? 0 : lat + 2;
    mem_lat = lat;
    for (int c = 0; c < 64 && got < 0; c++) begin
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = a;
      #2;
      if (c == 0) check({nm, " iREN in IDLE"}, word_t'(iREN), 32'd0);
      if (c == 1 && !exp_hit) begin
        check({nm, " iREN in FILL"}, word_t'(iREN), 32'd1);
        check({nm, " iaddr"}, iaddr, {a[31:2], 2'b00});
      end
      if (ihit) begin
        got = c;
        check({nm, " imemload"}, imemload, exp_data);
      end
    end
    check({nm, " hit cycle"}, word_t'(got), word_t'(want));
    @(negedge CLK);
    imemREN = 1'b0;
    #2;
    check({nm, " hit_count"}, hit_count, exp_hits);
    check({nm, " miss_count"}, miss_count, exp_misses);
  endtask

  typedef struct {
    bit    rst_before;
    word_t addr;
    int    lat;
    bit    exp_hit;
    word_t exp_data;
    word_t exp_hits;
    word_t exp_misses;
  } vec_t;

  vec_t tbl [11];

  // Reference model: which word address each frame currently holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_over[30'h00] = 32'h8C01_0004;
    mem_over[30'h01] = 32'h1111_1111;
    mem_over[30'h11] = 32'h2222_2222;

    //          rst   addr          lat hit data           hits          misses
    tbl[0]  = '{1'b1, 32'h0000_0000, 3, 1'b0, 32'h8C01_0004, 32'd1, 32'd1}; // cold miss
    tbl[1]  = '{1'b0, 32'h0000_0000, 0, 1'b1, 32'h8C01_0004, 32'd2, 32'd1}; // warm hit
    tbl[2]  = '{1'b0, 32'h0000_0000, 0, 1'b1, 32'h8C01_0004, 32'd3, 32'd1};
    tbl[3]  = '{1'b1, 32'h0000_0004, 1, 1'b0, 32'h1111_1111, 32'd1, 32'd1}; // conflict set
    tbl[4]  = '{1'b0, 32'h0000_0044, 2, 1'b0, 32'h2222_2222, 32'd2, 32'd2};
    tbl[5]  = '{1'b0, 32'h0000_0004, 0, 1'b0, 32'h1111_1111, 32'd3, 32'd3};
    tbl[6]  = '{1'b0, 32'h0000_0000, 1, 1'b0, 32'h8C01_0004, 32'd4, 32'd4};
    tbl[7]  = '{1'b0, 32'h0000_0003, 0, 1'b1, 32'h8C01_0004, 32'd5, 32'd4}; // byte alias
    tbl[8]  = '{1'b0, 32'h0000_0044, 4, 1'b0, 32'h2222_2222, 32'd6, 32'd5};
    tbl[9]  = '{1'b0, 32'h0000_0002, 0, 1'b1, 32'h8C01_0004, 32'd7, 32'd5};
    tbl[10] = '{1'b0, 32'h0000_0046, 0, 1'b1, 32'h2222_2222, 32'd8, 32'd5};

    // Reset state, with a fetch pending so ihit cannot hide behind imemREN=0
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0000;
    #12;
    check("reset ihit", word_t'(ihit), 32'd0);
    check("reset imemload", imemload, 32'd0);
    check("reset iREN", word_t'(iREN), 32'd0);
    check("reset iaddr", iaddr, 32'd0);
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
    imemREN = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      fetch(tbl[i].addr, tbl[i].lat, tbl[i].exp_hit, tbl[i].exp_data,
            tbl[i].exp_hits, tbl[i].exp_misses, $sformatf("vec%0d", i));
    end

    // Address change during FILL: fill keeps the captured address
    do_reset();
    mem_lat = 3;
    for (int c = 0; c <= 10; c++) begin
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = (c >= 2) ? 32'h0000_0020 : 32'h0000_0010;
      #2;
      if (c >= 1 && c <= 4) begin
        check($sformatf("addr-change iREN c%0d", c), word_t'(iREN), 32'd1);
        check($sformatf("addr-change iaddr c%0d", c), iaddr, 32'h0000_0010);
      end
      if (c == 5) begin
        check("addr-change idle iREN", word_t'(iREN), 32'd0);
        check("addr-change idle ihit", word_t'(ihit), 32'd0);
      end
      if (c == 6) check("addr-change refill iaddr", iaddr, 32'h0000_0020);
      if (c == 10) begin
        check("addr-change second ihit", word_t'(ihit), 32'd1);
        check("addr-change second data", imemload, mem_data(30'h8));
      end
    end
    @(negedge CLK);
    imemREN = 1'b0;
    #2;
    check("addr-change miss_count", miss_count, 32'd2);
    check("addr-change hit_count", hit_count, 32'd1);
    fetch(32'h0000_0010, 0, 1'b1, mem_data(30'h4), 32'd2, 32'd2, "addr-change first frame");

    // Reset in the middle of a fill
    do_reset();
    mem_lat = 10;
    for (int c = 0; c <= 3; c++) begin
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0008;
      #2;
    end
    check("mid-fill iREN before reset", word_t'(iREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    check("mid-fill iREN after reset", word_t'(iREN), 32'd0);
    check("mid-fill iaddr after reset", iaddr, 32'd0);
    check("mid-fill miss_count after reset", miss_count, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    fetch(32'h0000_0008, 1, 1'b0, mem_data(30'h2), 32'd1, 32'd1, "post-reset refetch");

    // Counter saturation via backdoor preload
    @(negedge CLK);
    #1;
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    fetch(32'h0000_0008, 0, 1'b1, mem_data(30'h2), 32'hFFFF_FFFF, 32'd1, "hit sat reach");
    fetch(32'h0000_0008, 0, 1'b1, mem_data(30'h2), 32'hFFFF_FFFF, 32'd1, "hit sat hold");
    @(negedge CLK);
    #1;
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    fetch(32'h0000_000C, 1, 1'b0, mem_data(30'h3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, "miss sat hold");

    // Randomized fetches against the direct-mapped reference model
    do_reset();
    begin
      word_t       m_hits;
      word_t       m_misses;
      m_hits   = '0;
      m_misses = '0;
      for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
      for (int n = 0; n < 200; n++) begin
        word_t       a;
        logic [29:0] w;
        int          s;
        bit          exp_hit;
        int          lat;
        w       = 30'($urandom_range(0, 63));
        a       = {w, 2'($urandom_range(0, 3))};
        s       = int'(w) % SETS;
        exp_hit = m_valid[s] && (m_word[s] == w);
        lat     = $urandom_range(0, 4);
        m_hits++;
        if (!exp_hit) m_misses++;
        fetch(a, lat, exp_hit, mem_data(w), m_hits, m_misses, $sformatf("rand%0d", n));
        m_valid[s] = 1'b1;
        m_word[s]  = w;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          @(negedge CLK);
          imemaddr = $urandom;
          #2;
          check($sformatf("rand%0d idle ihit", n), word_t'(ihit), 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
